// File: rtl/bounce_emulator.sv
// Contact-bounce emulator: turns a clean level change into a burst of LFSR-spaced toggles.
// Define BOUNCE_EMU_FIXED_GAP_EN to use a constant MIN_GAP spacing and drop the LFSR.
module bounce_emulator #(
    parameter int unsigned NBOUNCE = 4,
    parameter int unsigned GAPW    = 10,
    parameter int unsigned MIN_GAP = 16,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        clean_in,
    input  logic        bounce_en,
    output logic        bouncy_out,
    output logic        busy,
    output logic [15:0] event_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        BOUNCE = 1'b1
    } state_t;

    localparam logic [8:0] LAST_TOGGLE = 9'(2 * NBOUNCE);

    state_t      state_r;
    state_t      state_next_s;
    logic        sync1_r;
    logic        sync_in_r;
    logic        bouncy_out_r;
    logic        bouncy_next_s;
    logic        busy_r;
    logic [15:0] event_count_r;
    logic [15:0] count_next_s;
    logic [16:0] gap_cnt_r;
    logic [16:0] gap_next_s;
    logic [16:0] gap_s;
    logic [8:0]  toggles_r;
    logic [8:0]  toggles_next_s;

    // Two-flop synchronizer for the asynchronous clean level
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_r   <= 1'b0;
            sync_in_r <= 1'b0;
        end else begin
            sync1_r   <= clean_in;
            sync_in_r <= sync1_r;
        end
    end

`ifdef BOUNCE_EMU_FIXED_GAP_EN
    assign gap_s = 17'(MIN_GAP);
`else
    localparam logic [15:0] SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    function automatic logic [15:0] lfsr_step(input logic [15:0] value);
        logic [15:0] shifted;
        shifted = value >> 1;
        if (value[0]) begin
            return shifted ^ 16'hB400;
        end else begin
            return shifted;
        end
    endfunction

    logic [15:0] lfsr_r;

    // Free-running Galois LFSR supplying the random part of each gap
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            lfsr_r <= SEED_INIT;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    assign gap_s = 17'(MIN_GAP) + 17'(lfsr_r[GAPW-1:0]);
`endif

    // State and datapath registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r       <= IDLE;
            bouncy_out_r  <= 1'b0;
            busy_r        <= 1'b0;
            event_count_r <= 16'h0000;
            gap_cnt_r     <= 17'd0;
            toggles_r     <= 9'd0;
        end else begin
            state_r       <= state_next_s;
            bouncy_out_r  <= bouncy_next_s;
            busy_r        <= (state_next_s == BOUNCE);
            event_count_r <= count_next_s;
            gap_cnt_r     <= gap_next_s;
            toggles_r     <= toggles_next_s;
        end
    end

    // Next-state logic; inputs are only looked at while IDLE, so mid-burst changes wait their turn
    always_comb begin
        state_next_s   = state_r;
        bouncy_next_s  = bouncy_out_r;
        count_next_s   = event_count_r;
        gap_next_s     = gap_cnt_r;
        toggles_next_s = toggles_r;
        case (state_r)
            IDLE: begin
                if (sync_in_r != bouncy_out_r) begin
                    if (bounce_en) begin
                        state_next_s   = BOUNCE;
                        gap_next_s     = gap_s;
                        toggles_next_s = 9'd0;
                    end else begin
                        bouncy_next_s = sync_in_r;
                        count_next_s  = event_count_r + 16'd1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            BOUNCE: begin
                if (gap_cnt_r != 17'd0) begin
                    gap_next_s = gap_cnt_r - 17'd1;
                end else begin
                    bouncy_next_s  = ~bouncy_out_r;
                    toggles_next_s = toggles_r + 9'd1;
                    gap_next_s     = gap_s;
                    if (toggles_r == LAST_TOGGLE) begin
                        state_next_s = IDLE;
                        count_next_s = event_count_r + 16'd1;
                    end else begin
                        state_next_s = BOUNCE;
                    end
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign bouncy_out  = bouncy_out_r;
    assign busy        = busy_r;
    assign event_count = event_count_r;

endmodule

// File: doc/bounce_emulator.md
BOUNCE_EMULATOR -- requirements
Module: bounce_emulator

Interface
REQ-001 The block SHALL have parameter NBOUNCE, default 4: number of extra toggle pairs emitted per transition, legal range 1..255.
REQ-002 The block SHALL have parameter GAPW, default 10: bit width of the random part of each inter-toggle gap, legal range 1..15.
REQ-003 The block SHALL have parameter MIN_GAP, default 16: minimum gap in clock cycles, legal range 1..65535.
REQ-004 The block SHALL have parameter SEED, default 16'hACE1: the LFSR reset value.
REQ-005 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port clean_in, input, 1 bit: asynchronous clean level, e.g. SW[0].
REQ-008 The block SHALL have port bounce_en, input, 1 bit: 1 = emulate bounces; 0 = clean pass-through.
REQ-009 The block SHALL have port bouncy_out, output, 1 bit: emulated contact signal to drive a debouncer under test.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a bounce burst is in progress.
REQ-011 The block SHALL have port event_count, output, 16 bits: number of completed transitions, modulo 2^16.

Function
REQ-012 clean_in SHALL pass through a 2-flop synchronizer; sync_in is the second flop.
REQ-013 A 16-bit Galois LFSR SHALL run: mask 16'hB400, shift right, advance every cycle not in reset; SEED==0 SHALL load 16'h0001 instead.
REQ-014 Gap value G SHALL be MIN_GAP + lfsr[GAPW-1:0], zero-extended to 17 bits, sampled at each load.
REQ-015 FSM states SHALL be IDLE and BOUNCE; busy = (state==BOUNCE), registered.
REQ-016 In IDLE with sync_in != bouncy_out and bounce_en=0: bouncy_out <= sync_in next edge; event_count++; stay IDLE.
REQ-017 In IDLE with sync_in != bouncy_out and bounce_en=1: go to BOUNCE; gap_cnt <= G; toggles <= 0.
REQ-018 In BOUNCE, when gap_cnt != 0, gap_cnt SHALL decrement by one.
REQ-019 In BOUNCE, when gap_cnt == 0: toggle bouncy_out, increment toggles, reload gap_cnt <= G.
REQ-020 Consecutive toggles SHALL therefore be G+1 cycles apart; the first toggle SHALL occur G+1 cycles after busy rises.
REQ-021 On toggle number 2*NBOUNCE+1, the block SHALL return to IDLE on the same edge, with busy low and event_count++; bouncy_out then equals the level latched at burst start.
REQ-022 Changes of clean_in or bounce_en during BOUNCE SHALL be ignored; on return to IDLE, any mismatch SHALL start a new event the next cycle.
REQ-023 Simultaneous final toggle and new mismatch: the mismatch SHALL be evaluated in the following IDLE cycle; no toggle is lost or merged.
REQ-024 event_count SHALL wrap 16'hFFFF -> 16'h0000 silently.
REQ-025 bouncy_out SHALL be driven directly from a flop, with no combinational path from any input.

Reset
REQ-026 When reset=1 at a clock edge, the block SHALL set: state IDLE, bouncy_out 0, busy 0, event_count 0, gap_cnt 0, toggles 0, sync flops 0, LFSR to SEED (or 16'h0001 if SEED==0).
REQ-027 Reset during BOUNCE SHALL abort the burst immediately, with no pending toggle after reset release.
REQ-028 If clean_in=1 at reset release, the block SHALL see the mismatch 3 edges later and start an event.

Configuration
REQ-029 Macro BOUNCE_EMU_FIXED_GAP_EN SHALL control gap randomisation.
REQ-030 When BOUNCE_EMU_FIXED_GAP_EN is defined, G SHALL be the constant MIN_GAP and the LFSR SHALL be omitted.
REQ-031 When BOUNCE_EMU_FIXED_GAP_EN is undefined, G SHALL follow REQ-014.
REQ-032 Ports and all other behaviour SHALL be identical in both builds.

Verification
REQ-033 Fixed-gap build, NBOUNCE=2, MIN_GAP=4, bounce_en=1, clean_in 0->1: SHALL give 5 toggles 5 cycles apart, busy high exactly 25 cycles, final bouncy_out=1, event_count=1.
REQ-034 Same settings, bounce_en=0, clean_in 0->1->0 held 10 cycles each: bouncy_out SHALL follow with 3-cycle latency and no extra edges; event_count=2.
REQ-035 Fixed-gap build, clean_in toggled back 3 cycles into a burst: the first burst SHALL complete at level 1, a second burst SHALL start 1 cycle later and end at 0; event_count=2.
REQ-036 Reset asserted on cycle 7 of a burst: SHALL give bouncy_out=0, busy=0, event_count=0 the edge after, and no toggles while reset is held.
REQ-037 Random build, defaults, 100 transitions: every gap SHALL lie in [17, 1040] cycles, the first 3 gaps SHALL match the reference LFSR model from 16'hACE1, and event_count=100.
REQ-038 event_count preloaded by running 65536 bounce_en=0 events: event_count SHALL read 0 afterwards.
